// File: rtl/ab_arb_pkg.sv
// ab_arb_pkg
//  Shared types and helpers for the shared-unit arbiter.
//  - state_t : transaction sequencer states
//  - OUT_W_DEFAULT : default width of the shared unit result
//  - id_w(n) : width of a requester index for n requesters
package ab_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int OUT_W_DEFAULT = 6;

  // A single requester still needs a 1-bit id field to keep ports legal.
  function automatic int id_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ab_unit_arbiter_rr_picker.sv
// rr_picker
//  Combinational round-robin selector: returns the first set request bit
//  at or after rr_ptr, wrapping from NUM_REQ-1 back to 0.
//  Ports:
//   req       in   NUM_REQ  request levels
//   rr_ptr    in   ID_W     highest-priority index this round
//   winner    out  ID_W     selected requester (0 when none)
//   any_valid out  1        at least one request is set
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [ID_W-1:0]    winner,
  output logic               any_valid
);

  always_comb begin
    int idx;
    idx       = 0;
    winner    = '0;
    any_valid = |req;
    // Walk from lowest priority to highest so the last hit (the one closest
    // to rr_ptr) overrides earlier ones.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (req[idx]) begin
        winner = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/ab_unit_arbiter.sv
// ab_unit_arbiter
//  Shares one 2-input compute unit between NUM_REQ requesters. A round-robin
//  winner's a/b operands are latched and held on the unit for LAT cycles; the
//  unit result is then captured and returned tagged with the requester id.
//  One transaction in flight at a time: IDLE -> ISSUE -> WAIT -> RESP.
//  Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req/req_a/req_b     per-requester request level and operands
//   gnt                 one-hot grant pulse (ISSUE cycle)
//   unit_a/unit_b       operands driven to the shared unit
//   unit_out            shared unit result
//   rsp_valid           response pulse (RESP cycle)
//   rsp_id/rsp_data     owner id and captured result, held between pulses
module ab_unit_arbiter
  import ab_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int OUT_W   = OUT_W_DEFAULT,
  parameter int LAT     = 1,
  localparam int ID_W   = id_w(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] req_a,
  input  logic [NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0] gnt,
  output logic               unit_a,
  output logic               unit_b,
  input  logic [OUT_W-1:0]   unit_out,
  output logic               rsp_valid,
  output logic [ID_W-1:0]    rsp_id,
  output logic [OUT_W-1:0]   rsp_data
);

  state_t               state_q, state_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]      winner_q, winner_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 a_q, a_d;
  logic                 b_q, b_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
  logic [OUT_W-1:0]     rsp_data_q, rsp_data_d;

  logic [ID_W-1:0]      pick;
  logic                 pick_valid;
  logic                 enter_resp;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req       (req),
    .rr_ptr    (rr_ptr_q),
    .winner    (pick),
    .any_valid (pick_valid)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    winner_d    = winner_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    gnt_d       = '0;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    enter_resp  = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          winner_d    = pick;
          a_d         = req_a[pick];
          b_d         = req_b[pick];
          gnt_d[pick] = 1'b1;  // registered so it is high during ISSUE
          rr_ptr_d    = (pick == ID_W'(NUM_REQ - 1)) ? '0 : pick + ID_W'(1);
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (LAT == 0) begin
          enter_resp = 1'b1;
        end else begin
          cnt_d   = 4'(LAT);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd1) begin
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Result is sampled on the edge that enters RESP, after a/b have been
    // stable on the unit for LAT full cycles.
    if (enter_resp) begin
      state_d     = RESP;
      rsp_valid_d = 1'b1;
      rsp_data_d  = unit_out;
      rsp_id_d    = winner_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      winner_q    <= '0;
      cnt_q       <= '0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      gnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      winner_q    <= winner_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign gnt       = gnt_q;
  assign unit_a    = a_q;
  assign unit_b    = b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_ab_unit_arbiter.sv
// tb_ab_unit_arbiter
//  Three arbiter instances (LAT = 1, 4, 0) share the requester stimulus.
//  Each drives its own model of the shared unit: out = {a, b, a^b, 3'b101}.
module tb_ab_unit_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req, req_a, req_b;

  logic [1:0] gnt1, gnt4, gnt0;
  logic       ua1, ub1, ua4, ub4, ua0, ub0;
  logic [5:0] uo1, uo4, uo0;
  logic       rv1, rv4, rv0;
  logic       ri1, ri4, ri0;
  logic [5:0] rd1, rd4, rd0;

  assign uo1 = {ua1, ub1, ua1 ^ ub1, 3'b101};
  assign uo4 = {ua4, ub4, ua4 ^ ub4, 3'b101};
  assign uo0 = {ua0, ub0, ua0 ^ ub0, 3'b101};

  always #5 clk = ~clk;

  ab_unit_arbiter #(.NUM_REQ(2), .OUT_W(6), .LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt1), .unit_a(ua1), .unit_b(ub1), .unit_out(uo1),
    .rsp_valid(rv1), .rsp_id(ri1), .rsp_data(rd1)
  );

  ab_unit_arbiter #(.NUM_REQ(2), .OUT_W(6), .LAT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt4), .unit_a(ua4), .unit_b(ub4), .unit_out(uo4),
    .rsp_valid(rv4), .rsp_id(ri4), .rsp_data(rd4)
  );

  ab_unit_arbiter #(.NUM_REQ(2), .OUT_W(6), .LAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt0), .unit_a(ua0), .unit_b(ub0), .unit_out(uo0),
    .rsp_valid(rv0), .rsp_id(ri0), .rsp_data(rd0)
  );

  // Observation mux: which instance the current test looks at.
  int         sel;
  logic [1:0] o_gnt;
  logic       o_ua, o_ub, o_rv, o_id;
  logic [5:0] o_data;

  always_comb begin
    o_gnt = gnt1; o_ua = ua1; o_ub = ub1; o_rv = rv1; o_id = ri1; o_data = rd1;
    case (sel)
      4: begin o_gnt = gnt4; o_ua = ua4; o_ub = ub4; o_rv = rv4; o_id = ri4; o_data = rd4; end
      0: begin o_gnt = gnt0; o_ua = ua0; o_ub = ub0; o_rv = rv0; o_id = ri0; o_data = rd0; end
      default: ;
    endcase
  end

  typedef struct {
    logic [1:0] req;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] exp_gnt;
    logic       exp_ua;
    logic       exp_ub;
    logic       exp_id;
    logic [5:0] exp_data;
  } vec_t;

  vec_t tbl [6];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = '0; req_a = '0; req_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One complete transaction starting from IDLE on instance s with latency lat.
  task automatic run_txn(input int s, input int lat, input vec_t v);
    sel = s;
    @(negedge clk);
    req = v.req; req_a = v.a; req_b = v.b;
    @(posedge clk); #1;
    check("gnt", o_gnt, v.exp_gnt);
    check("unit_a", o_ua, v.exp_ua);
    check("unit_b", o_ub, v.exp_ub);
    check("rsp_valid_issue", o_rv, 0);
    req = '0;
    repeat (lat) begin
      @(posedge clk); #1;
      check("rsp_valid_wait", o_rv, 0);
    end
    @(posedge clk); #1;
    check("rsp_valid", o_rv, 1);
    check("rsp_id", o_id, v.exp_id);
    check("rsp_data", o_data, v.exp_data);
    $display("txn dut_lat=%0d req=%b gnt_exp=%b id=%0d data=%b", lat, v.req, v.exp_gnt, o_id, o_data);
    @(posedge clk); #1;
    check("rsp_valid_after", o_rv, 0);
  endtask

  initial begin
    logic [1:0] eg;
    logic       seen;
    vec_t       v;

    //          req    a      b      gnt    ua    ub    id    data
    tbl[0] = '{2'b01, 2'b01, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 6'b101101};
    tbl[1] = '{2'b11, 2'b10, 2'b11, 2'b10, 1'b1, 1'b1, 1'b1, 6'b110101};
    tbl[2] = '{2'b10, 2'b00, 2'b10, 2'b10, 1'b0, 1'b1, 1'b1, 6'b011101};
    tbl[3] = '{2'b11, 2'b01, 2'b10, 2'b01, 1'b1, 1'b0, 1'b0, 6'b101101};
    tbl[4] = '{2'b01, 2'b11, 2'b01, 2'b01, 1'b1, 1'b1, 1'b0, 6'b110101};
    tbl[5] = '{2'b10, 2'b10, 2'b00, 2'b10, 1'b1, 1'b0, 1'b1, 6'b101101};

    sel = 1;
    rst_n = 1'b1;
    req = '0; req_a = '0; req_b = '0;
    #2 rst_n = 1'b0;
    #1;
    check("reset_gnt", o_gnt, 0);
    check("reset_unit_a", o_ua, 0);
    check("reset_rsp_valid", o_rv, 0);
    check("reset_rsp_id", o_id, 0);
    check("reset_rsp_data", o_data, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: back-to-back single transactions on LAT=1, rr_ptr evolving.
    for (int i = 0; i < 6; i++) begin
      run_txn(1, 1, tbl[i]);
    end

    // Contention: both requesters held, strict alternation every 4 cycles.
    do_reset();
    sel = 1;
    @(negedge clk);
    req = 2'b11; req_a = 2'b01; req_b = 2'b10;
    for (int k = 0; k < 4; k++) begin
      eg = (k % 2 == 0) ? 2'b01 : 2'b10;
      @(posedge clk); #1;
      check("contend_gnt", o_gnt, eg);
      @(posedge clk); #1;
      check("contend_wait_rv", o_rv, 0);
      @(posedge clk); #1;
      check("contend_rv", o_rv, 1);
      check("contend_id", o_id, k % 2);
      check("contend_data", o_data, (k % 2 == 0) ? 6'b101101 : 6'b011101);
      $display("txn contend k=%0d gnt=%b id=%0d data=%b", k, eg, o_id, o_data);
      @(posedge clk); #1;
      check("contend_idle_rv", o_rv, 0);
      check("contend_idle_gnt", o_gnt, 0);
    end

    // Operands change after grant: transaction in flight unaffected.
    do_reset();
    sel = 1;
    @(negedge clk);
    req = 2'b01; req_a = 2'b01; req_b = 2'b00;
    @(posedge clk); #1;
    check("opchg_gnt", o_gnt, 2'b01);
    req = '0; req_a = 2'b00; req_b = 2'b11;
    @(posedge clk); #1;
    check("opchg_unit_a", o_ua, 1);
    check("opchg_unit_b", o_ub, 0);
    @(posedge clk); #1;
    check("opchg_rv", o_rv, 1);
    check("opchg_data", o_data, 6'b101101);
    check("opchg_unit_a_resp", o_ua, 1);
    $display("txn opchg data=%b", o_data);

    // Reset mid-WAIT on LAT=4 after a completed transaction left state behind.
    do_reset();
    v = '{2'b10, 2'b10, 2'b10, 2'b10, 1'b1, 1'b1, 1'b1, 6'b110101};
    run_txn(4, 4, v);
    @(negedge clk);
    req = 2'b01; req_a = 2'b01; req_b = 2'b01;
    @(posedge clk); #1;
    check("midrst_gnt", o_gnt, 2'b01);
    req = '0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_gnt0", o_gnt, 0);
    check("midrst_unit_a", o_ua, 0);
    check("midrst_unit_b", o_ub, 0);
    check("midrst_rv", o_rv, 0);
    check("midrst_id", o_id, 0);
    check("midrst_data", o_data, 0);
    $display("txn midrst outputs gnt=%b ua=%b id=%0d data=%b", o_gnt, o_ua, o_id, o_data);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      seen = seen | o_rv | (|o_gnt) | o_ua;
    end
    check("midrst_quiet", seen, 0);

    // LAT=0 single request, then a request withdrawn before the edge.
    do_reset();
    v = '{2'b10, 2'b10, 2'b00, 2'b10, 1'b1, 1'b0, 1'b1, 6'b101101};
    run_txn(0, 0, v);
    @(negedge clk);
    req = 2'b01; req_a = 2'b01;
    #2 req = '0;
    @(posedge clk); #1;
    check("drop_gnt", o_gnt, 0);
    @(posedge clk); #1;
    check("drop_gnt2", o_gnt, 0);
    check("drop_rv", o_rv, 0);
    $display("txn drop gnt=%b rv=%b", o_gnt, o_rv);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
